mem_burst_reader: RTL and testbench

MEM_BURST_READER -- requirements
Module: mem_burst_reader

---
 rtl/mem_burst_reader_pkg.sv | 36 +++
 rtl/mem_burst_reader_fifo.sv | 100 ++++++++++
 rtl/mem_burst_reader.sv | 228 ++++++++++++++++++++++
 tb/tb_mem_burst_reader.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_burst_reader_pkg.sv
// -----------------------------------------------------------------------------
// mem_burst_reader_pkg
// Shared definitions for the burst reader and its buffering FIFO:
//   - FSM state encoding of the burst controller
//   - legal range of the memory read latency
//   - width helpers so that depth and pointer/counter sizes follow the
//     parameters instead of being written as fixed numbers
// -----------------------------------------------------------------------------
package mem_burst_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } burst_state_e;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 4;

    // One slot per read that can be in flight plus one slot for the beat
    // currently presented to the consumer: enough for gap-free streaming.
    function automatic int fifo_depth(input int rd_lat);
        return rd_lat + 1;
    endfunction

    // Bits needed to index a FIFO of the given depth.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Bits needed to hold an occupancy count of 0..depth.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/mem_burst_reader_fifo.sv
// -----------------------------------------------------------------------------
// burst_fifo
// First-word-fall-through FIFO buffering returned read data together with its
// end-of-burst flag. The head entry is visible on 'head' while 'empty' is low.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   flush        empties the FIFO (wins over push and pop)
//   push         write push_data (ignored when full and not popping)
//   push_data    WIDTH-bit entry
//   pop          consume the head entry (ignored when empty)
//   head         current head entry
//   empty        no entry stored
//   count        current occupancy 0..DEPTH
// -----------------------------------------------------------------------------
module burst_fifo
    import mem_burst_reader_pkg::*;
#(
    parameter int WIDTH = 33,
    parameter int DEPTH = 2,
    localparam int PTR_W = ptr_width(DEPTH),
    localparam int CNT_W = cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             do_push_s;
    logic             do_pop_s;

    // Pointer advance with explicit wrap, since DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return {PTR_W{1'b0}};
        end else begin
            return p + {{(PTR_W-1){1'b0}}, 1'b1};
        end
    endfunction

    // Qualify push/pop: flush dominates, a full FIFO only accepts a push
    // when the head is leaving in the same cycle.
    always_comb begin
        do_pop_s  = 1'b0;
        do_push_s = 1'b0;
        if (flush) begin
            do_pop_s  = 1'b0;
            do_push_s = 1'b0;
        end else begin
            do_pop_s  = pop && (count_r != {CNT_W{1'b0}});
            do_push_s = push && ((count_r != CNT_W'(DEPTH)) || do_pop_s);
        end
    end

    // Storage array; contents are only observable through valid pointers.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (do_pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
                2'b01:   count_r <= count_r - {{(CNT_W-1){1'b0}}, 1'b1};
                default: count_r <= count_r;
            endcase
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign empty = (count_r == {CNT_W{1'b0}});
    assign count = count_r;

endmodule

// File: rtl/mem_burst_reader.sv
// -----------------------------------------------------------------------------
// mem_burst_reader
// Reads a burst of 'len' consecutive words from a fixed-latency memory and
// streams them out on a valid/ready interface, marking the final beat.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, start_addr,
//   len                 burst request (sampled while idle)
//   abort               cancel the running burst
//   busy, done          status: burst active / one-cycle completion pulse
//   mem_en, mem_addr    memory read request
//   mem_data            read data, valid RD_LAT cycles after mem_en
//   data_out, valid,
//   last, ready         output stream
// -----------------------------------------------------------------------------
module mem_burst_reader
    import mem_burst_reader_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [LEN_W-1:0]  len,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic [DATA_W-1:0] data_out,
    output logic              valid,
    output logic              last,
    input  logic              ready
);

    localparam int DEPTH = fifo_depth(RD_LAT);
    localparam int CNT_W = cnt_width(DEPTH);
    // Wide enough for in-flight reads plus FIFO occupancy (at most 2*DEPTH).
    localparam int SUM_W = CNT_W + 1;

    if ((RD_LAT < RD_LAT_MIN) || (RD_LAT > RD_LAT_MAX)) begin : g_rd_lat_illegal
        $error("mem_burst_reader: RD_LAT outside the supported range");
    end

    burst_state_e      state_r;
    burst_state_e      state_nxt;
    logic [ADDR_W-1:0] addr_r;
    logic [LEN_W-1:0]  rem_r;
    logic              done_r;
    logic [RD_LAT-1:0] pipe_vld_r;
    logic [RD_LAT-1:0] pipe_last_r;

    logic              abort_s;
    logic              start_ok_s;
    logic              len_zero_s;
    logic              last_issue_s;
    logic              credit_ok_s;
    logic [SUM_W-1:0]  inflight_s;
    logic              busy_s;
    logic              mem_en_s;

    logic              fifo_push_s;
    logic              fifo_pop_s;
    logic [DATA_W:0]   fifo_head_s;
    logic              fifo_empty_s;
    logic [CNT_W-1:0]  fifo_count_s;
    logic              valid_s;
    logic              last_accept_s;

    assign abort_s       = abort && (state_r != ST_IDLE);
    assign start_ok_s    = start && (state_r == ST_IDLE);
    assign len_zero_s    = (len == {LEN_W{1'b0}});
    assign last_issue_s  = (rem_r == {{(LEN_W-1){1'b0}}, 1'b1});
    assign valid_s       = !fifo_empty_s;
    // Abort takes priority over a beat handed over in the same cycle.
    assign fifo_pop_s    = valid_s && ready && !abort_s;
    assign last_accept_s = fifo_pop_s && fifo_head_s[DATA_W];
    // Returned data is dropped once the burst is aborted.
    assign fifo_push_s   = pipe_vld_r[RD_LAT-1] && !abort_s;

    // Number of reads issued whose data has not yet entered the FIFO.
    always_comb begin
        inflight_s = {SUM_W{1'b0}};
        for (int i = 0; i < RD_LAT; i++) begin
            inflight_s = inflight_s + {{(SUM_W-1){1'b0}}, pipe_vld_r[i]};
        end
    end

    // A new read is allowed only if its data is guaranteed a FIFO slot.
    // A beat leaving this cycle frees its slot, which keeps the stream
    // gap-free at one beat per cycle.
    assign credit_ok_s = (inflight_s + SUM_W'(fifo_count_s))
                         < (SUM_W'(DEPTH) + {{(SUM_W-1){1'b0}}, fifo_pop_s});

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start && !len_zero_s) begin
                    state_nxt = ST_RUN;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (abort_s) begin
                    state_nxt = ST_IDLE;
                end else if (mem_en_s && last_issue_s) begin
                    state_nxt = ST_DRAIN;
                end else begin
                    state_nxt = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (abort_s || last_accept_s) begin
                    state_nxt = ST_IDLE;
                end else begin
                    state_nxt = ST_DRAIN;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM outputs.
    always_comb begin
        busy_s   = 1'b0;
        mem_en_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                busy_s   = 1'b0;
                mem_en_s = 1'b0;
            end
            ST_RUN: begin
                busy_s   = 1'b1;
                mem_en_s = !abort_s && credit_ok_s;
            end
            ST_DRAIN: begin
                busy_s   = 1'b1;
                mem_en_s = 1'b0;
            end
            default: begin
                busy_s   = 1'b0;
                mem_en_s = 1'b0;
            end
        endcase
    end

    // Burst address / remaining-read counter and the completion pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_r <= {ADDR_W{1'b0}};
            rem_r  <= {LEN_W{1'b0}};
            done_r <= 1'b0;
        end else begin
            if (start_ok_s && !len_zero_s) begin
                addr_r <= start_addr;
                rem_r  <= len;
            end else if (mem_en_s) begin
                addr_r <= addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                rem_r  <= rem_r - {{(LEN_W-1){1'b0}}, 1'b1};
            end
            done_r <= (start_ok_s && len_zero_s)
                      || ((state_r == ST_DRAIN) && last_accept_s);
        end
    end

    // Read-return tracker: one stage per cycle of memory latency; the last
    // flag travels alongside so the FIFO entry knows it ends the burst.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_vld_r  <= {RD_LAT{1'b0}};
            pipe_last_r <= {RD_LAT{1'b0}};
        end else if (abort_s) begin
            pipe_vld_r  <= {RD_LAT{1'b0}};
            pipe_last_r <= {RD_LAT{1'b0}};
        end else begin
            pipe_vld_r[0]  <= mem_en_s;
            pipe_last_r[0] <= mem_en_s && last_issue_s;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_vld_r[i]  <= pipe_vld_r[i-1];
                pipe_last_r[i] <= pipe_last_r[i-1];
            end
        end
    end

    burst_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (abort_s),
        .push      (fifo_push_s),
        .push_data ({pipe_last_r[RD_LAT-1], mem_data}),
        .pop       (fifo_pop_s),
        .head      (fifo_head_s),
        .empty     (fifo_empty_s),
        .count     (fifo_count_s)
    );

    assign busy     = busy_s;
    assign done     = done_r;
    assign mem_en   = mem_en_s;
    assign mem_addr = addr_r;
    assign valid    = valid_s;
    // Stale FIFO contents are masked so the stream reads zero when idle.
    assign data_out = valid_s ? fifo_head_s[DATA_W-1:0] : {DATA_W{1'b0}};
    assign last     = valid_s && fifo_head_s[DATA_W];

endmodule

// File: tb/tb_mem_burst_reader.sv
// -----------------------------------------------------------------------------
// tb_mem_burst_reader
// Two readers (RD_LAT=1 and RD_LAT=3) driven by directed bursts against a
// latency-accurate memory model; a per-cycle burst model checks addresses,
// beat data/order, last, busy, done and outstanding-read bound.
// -----------------------------------------------------------------------------
module tb_mem_burst_reader;

    logic        clk;
    logic        rst_n;
    logic        start_v    [2];
    logic [7:0]  addr_in    [2];
    logic [7:0]  len_in     [2];
    logic        abort_v    [2];
    logic        ready_v    [2];
    logic        busy_v     [2];
    logic        done_v     [2];
    logic        mem_en_v   [2];
    logic [7:0]  mem_addr_v [2];
    logic [31:0] mem_data_v [2];
    logic [31:0] data_v     [2];
    logic        valid_v    [2];
    logic        last_v     [2];

    int total = 0;
    int bad   = 0;

    // Burst model state
    bit          busy_m     [2];
    bit          done_m     [2];
    logic [7:0]  base_m     [2];
    logic [7:0]  len_m      [2];
    logic [7:0]  iss_addr_m [2];
    int          acc_m      [2];
    int          iss_cnt_m  [2];
    int          out_m      [2];
    int          depth_m    [2] = '{2, 4};

    // Memory model history
    logic [7:0]  ah   [2][4];
    logic        en_h [2][4];

    logic [7:0]  cap [8];
    int          ncap;
    bit          got;
    int          fv;
    int          dc;
    int          n;

    logic [31:0] t1_exp [4] = '{32'hC0FFEE10, 32'hC0FFEE11, 32'hC0FFEE12, 32'hC0FFEE13};
    logic [7:0]  t3_exp [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};

    function automatic logic [31:0] word(input logic [7:0] a);
        return {24'hC0FFEE, a};
    endfunction

    mem_burst_reader #(.DATA_W(32), .ADDR_W(8), .LEN_W(8), .RD_LAT(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .start_addr(addr_in[0]),
        .len(len_in[0]), .abort(abort_v[0]), .busy(busy_v[0]), .done(done_v[0]),
        .mem_en(mem_en_v[0]), .mem_addr(mem_addr_v[0]), .mem_data(mem_data_v[0]),
        .data_out(data_v[0]), .valid(valid_v[0]), .last(last_v[0]), .ready(ready_v[0])
    );

    mem_burst_reader #(.DATA_W(32), .ADDR_W(8), .LEN_W(8), .RD_LAT(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .start_addr(addr_in[1]),
        .len(len_in[1]), .abort(abort_v[1]), .busy(busy_v[1]), .done(done_v[1]),
        .mem_en(mem_en_v[1]), .mem_addr(mem_addr_v[1]), .mem_data(mem_data_v[1]),
        .data_out(data_v[1]), .valid(valid_v[1]), .last(last_v[1]), .ready(ready_v[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: returns word(addr) exactly RD_LAT cycles after the read strobe.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                for (int i = 0; i < 4; i++) begin
                    ah[k][i]   <= 8'h00;
                    en_h[k][i] <= 1'b0;
                end
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                for (int i = 3; i > 0; i--) begin
                    ah[k][i]   <= ah[k][i-1];
                    en_h[k][i] <= en_h[k][i-1];
                end
                ah[k][0]   <= mem_addr_v[k];
                en_h[k][0] <= mem_en_v[k];
            end
        end
    end
    assign mem_data_v[0] = en_h[0][0] ? word(ah[0][0]) : 32'hDEADBEEF;
    assign mem_data_v[1] = en_h[1][2] ? word(ah[1][2]) : 32'hDEADBEEF;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One cycle of the burst model for reader k, evaluated mid-cycle.
    task automatic model_step(input int k);
        bit nxt_busy;
        bit nxt_done;
        chk($sformatf("busy[%0d]", k), busy_v[k], busy_m[k]);
        chk($sformatf("done[%0d]", k), done_v[k], done_m[k]);
        if (!busy_m[k]) begin
            chk($sformatf("idle_valid[%0d]", k), valid_v[k], 1'b0);
            chk($sformatf("idle_mem_en[%0d]", k), mem_en_v[k], 1'b0);
        end
        if (abort_v[k] && busy_m[k]) begin
            chk($sformatf("abort_mem_en[%0d]", k), mem_en_v[k], 1'b0);
        end
        nxt_busy = busy_m[k];
        nxt_done = 1'b0;
        if (mem_en_v[k] && busy_m[k]) begin
            chk($sformatf("mem_addr[%0d]", k), mem_addr_v[k], iss_addr_m[k]);
            iss_addr_m[k] = iss_addr_m[k] + 8'd1;
            iss_cnt_m[k]++;
            out_m[k]++;
            chk($sformatf("issue_over_len[%0d]", k), iss_cnt_m[k] <= int'(len_m[k]), 1'b1);
        end
        if (valid_v[k] && busy_m[k]) begin
            chk($sformatf("data[%0d]", k), data_v[k], word(8'(base_m[k] + 8'(acc_m[k]))));
            chk($sformatf("last[%0d]", k), last_v[k], acc_m[k] == int'(len_m[k]) - 1);
            if (ready_v[k]) begin
                acc_m[k]++;
                out_m[k]--;
                if (acc_m[k] == int'(len_m[k])) begin
                    nxt_busy = 1'b0;
                    nxt_done = 1'b1;
                end
            end
        end
        if (busy_m[k]) begin
            chk($sformatf("outstanding[%0d]", k), out_m[k] <= depth_m[k], 1'b1);
        end
        if (abort_v[k] && busy_m[k]) begin
            nxt_busy = 1'b0;
            nxt_done = 1'b0;
            out_m[k] = 0;
        end
        if (start_v[k] && !busy_m[k]) begin
            if (len_in[k] == 8'd0) begin
                nxt_done = 1'b1;
            end else begin
                nxt_busy      = 1'b1;
                base_m[k]     = addr_in[k];
                len_m[k]      = len_in[k];
                iss_addr_m[k] = addr_in[k];
                acc_m[k]      = 0;
                iss_cnt_m[k]  = 0;
                out_m[k]      = 0;
            end
        end
        busy_m[k] = nxt_busy;
        done_m[k] = nxt_done;
    endtask

    // Compare process: model and DUT outputs checked every cycle.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                busy_m[k] = 1'b0;
                done_m[k] = 1'b0;
                out_m[k]  = 0;
            end else begin
                model_step(k);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input int k, input string tag);
        chk($sformatf("%s_busy[%0d]", tag, k), busy_v[k], 1'b0);
        chk($sformatf("%s_done[%0d]", tag, k), done_v[k], 1'b0);
        chk($sformatf("%s_mem_en[%0d]", tag, k), mem_en_v[k], 1'b0);
        chk($sformatf("%s_mem_addr[%0d]", tag, k), mem_addr_v[k], 8'h00);
        chk($sformatf("%s_valid[%0d]", tag, k), valid_v[k], 1'b0);
        chk($sformatf("%s_last[%0d]", tag, k), last_v[k], 1'b0);
        chk($sformatf("%s_data[%0d]", tag, k), data_v[k], 32'h0);
    endtask

    // Start a burst in the next cycle (cycle 0) and run until done or budget.
    task automatic run_burst(input int k, input logic [7:0] a, input logic [7:0] l,
                             input bit tog, input int budget);
        got  = 1'b0;
        fv   = -1;
        dc   = -1;
        ncap = 0;
        tick();
        start_v[k] = 1'b1;
        addr_in[k] = a;
        len_in[k]  = l;
        ready_v[k] = 1'b1;
        for (int c = 1; c <= budget && !got; c++) begin
            tick();
            start_v[k] = 1'b0;
            if (tog) ready_v[k] = ~ready_v[k];
            @(negedge clk);
            if (valid_v[k] && fv < 0) fv = c;
            if (mem_en_v[k] && ncap < 8) begin
                cap[ncap] = mem_addr_v[k];
                ncap++;
            end
            if (done_v[k]) begin
                got = 1'b1;
                dc  = c;
            end
        end
        ready_v[k] = 1'b1;
        chk($sformatf("burst_done_seen[%0d]", k), got, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            start_v[k] = 1'b0;
            addr_in[k] = 8'h00;
            len_in[k]  = 8'd0;
            abort_v[k] = 1'b0;
            ready_v[k] = 1'b1;
        end
        repeat (2) @(posedge clk);
        #1;
        check_zero(0, "reset");
        check_zero(1, "reset");
        rst_n = 1'b1;

        // T1: RD_LAT=1, 0x10, len 4, ready high: beats in cycles 3..6, done 7
        tick();
        start_v[0] = 1'b1;
        addr_in[0] = 8'h10;
        len_in[0]  = 8'd4;
        for (int c = 1; c <= 7; c++) begin
            tick();
            start_v[0] = 1'b0;
            @(negedge clk);
            if (c < 3) begin
                chk("t1_pre_valid", valid_v[0], 1'b0);
            end else if (c <= 6) begin
                chk("t1_valid", valid_v[0], 1'b1);
                chk("t1_data", data_v[0], t1_exp[c-3]);
                chk("t1_last", last_v[0], c == 6);
                chk("t1_no_early_done", done_v[0], 1'b0);
            end else begin
                chk("t1_done", done_v[0], 1'b1);
                chk("t1_busy_low", busy_v[0], 1'b0);
                chk("t1_valid_low", valid_v[0], 1'b0);
            end
        end

        // T2: RD_LAT=3, len 8, ready toggling
        run_burst(1, 8'h40, 8'd8, 1'b1, 80);
        chk("t2_first_valid_cycle", fv, 5);
        chk("t2_beats", acc_m[1], 8);
        chk("t2_reads", ncap, 8);

        // T3: address wrap
        run_burst(0, 8'hFE, 8'd4, 1'b0, 20);
        chk("t3_reads", ncap, 4);
        for (int i = 0; i < 4; i++) chk("t3_addr", cap[i], t3_exp[i]);
        chk("t3_first_valid_cycle", fv, 3);
        chk("t3_done_cycle", dc, 7);

        // T4: zero-length burst
        run_burst(0, 8'h33, 8'd0, 1'b0, 6);
        chk("t4_done_cycle", dc, 1);
        chk("t4_no_reads", ncap, 0);
        chk("t4_no_valid", fv, -1);
        for (int c = 0; c < 3; c++) begin
            tick();
            @(negedge clk);
            chk("t4_after_done", done_v[0], 1'b0);
            chk("t4_after_valid", valid_v[0], 1'b0);
        end

        // T5: abort after 2 of 6 beats with ready low
        tick();
        start_v[1] = 1'b1;
        addr_in[1] = 8'h80;
        len_in[1]  = 8'd6;
        ready_v[1] = 1'b1;
        n = 0;
        for (int c = 1; c <= 30 && n < 2; c++) begin
            tick();
            start_v[1] = 1'b0;
            @(negedge clk);
            if (valid_v[1] && ready_v[1]) n++;
        end
        chk("t5_two_beats", n, 2);
        tick();
        ready_v[1] = 1'b0;
        repeat (2) tick();
        abort_v[1] = 1'b1;
        @(negedge clk);
        chk("t5_busy_in_abort_cycle", busy_v[1], 1'b1);
        chk("t5_valid_in_abort_cycle", valid_v[1], 1'b1);
        tick();
        abort_v[1] = 1'b0;
        @(negedge clk);
        chk("t5_valid_after_abort", valid_v[1], 1'b0);
        chk("t5_busy_after_abort", busy_v[1], 1'b0);
        chk("t5_done_after_abort", done_v[1], 1'b0);
        for (int c = 0; c < 3; c++) begin
            tick();
            @(negedge clk);
            chk("t5_no_done", done_v[1], 1'b0);
            chk("t5_no_mem_en", mem_en_v[1], 1'b0);
        end
        run_burst(1, 8'h20, 8'd3, 1'b0, 20);
        chk("t5_restart_first_valid", fv, 5);
        chk("t5_restart_done_cycle", dc, 8);

        // T6: reset mid-burst on both readers
        tick();
        start_v[0] = 1'b1; addr_in[0] = 8'h30; len_in[0] = 8'd6;
        start_v[1] = 1'b1; addr_in[1] = 8'h70; len_in[1] = 8'd5;
        repeat (3) begin
            tick();
            start_v[0] = 1'b0;
            start_v[1] = 1'b0;
        end
        chk("t6_pre_reset_busy", busy_v[0], 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero(0, "t6");
        check_zero(1, "t6");
        tick();
        rst_n = 1'b1;
        run_burst(0, 8'h50, 8'd5, 1'b0, 20);
        chk("t6_done_cycle", dc, 8);
        chk("t6_reads", ncap, 5);
        run_burst(1, 8'h60, 8'd2, 1'b1, 30);
        chk("t6_beats", acc_m[1], 2);

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
